// File: rtl/wb_set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// A miss latches its victim way and address so the writeback/refill/install sequence stays consistent.
module wb_set_assoc_cache #(
    parameter int  LINE_W    = 32,
    parameter int  WAYS_LOG2 = 2,
    parameter int  INDEX_W   = 4,
    parameter int  OFFSET_W  = 2,
    parameter int  ADDR_W    = 32,
    localparam int NWAYS     = 2 ** WAYS_LOG2,
    localparam int NSETS     = 2 ** INDEX_W,
    localparam int BLOCK_W   = LINE_W << OFFSET_W,
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W - 2,
    localparam int MADDR_W   = ADDR_W - OFFSET_W - 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               c_read_i,
    input  logic               c_wr_i,
    input  logic [LINE_W-1:0]  c_write_data_i,
    output logic [LINE_W-1:0]  c_data_o,
    output logic               c_busywait_o,
    output logic               c_m_read_o,
    output logic               c_m_wr_o,
    output logic [MADDR_W-1:0] c_m_address_o,
    output logic [BLOCK_W-1:0] c_m_write_data_o,
    input  logic [BLOCK_W-1:0] c_m_read_data_i,
    input  logic               c_m_busywait_i,
    input  logic               m_read_done,
    input  logic               m_write_done
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, INSTALL} state_t;
    typedef logic [WAYS_LOG2-1:0] way_t;
    typedef logic [NWAYS-1:0][WAYS_LOG2-1:0] ages_t;

    state_t             state_q, state_d;
    logic [NWAYS-1:0]   valid_q [NSETS];
    logic [NWAYS-1:0]   valid_d [NSETS];
    logic [NWAYS-1:0]   dirty_q [NSETS];
    logic [NWAYS-1:0]   dirty_d [NSETS];
    logic [TAG_W-1:0]   tag_q   [NSETS][NWAYS];
    logic [TAG_W-1:0]   tag_d   [NSETS][NWAYS];
    logic [BLOCK_W-1:0] data_q  [NSETS][NWAYS];
    logic [BLOCK_W-1:0] data_d  [NSETS][NWAYS];
    ages_t              age_q   [NSETS];
    ages_t              age_d   [NSETS];
    way_t               victim_q, victim_d;
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic [BLOCK_W-1:0] refill_q, refill_d;

    logic [TAG_W-1:0]           req_tag, miss_tag;
    logic [INDEX_W-1:0]         req_idx, miss_idx;
    logic [OFFSET_W-1:0]        req_off;
    logic [$clog2(BLOCK_W)-1:0] word_lsb;
    logic                       req, hit, lookup_hit, miss, found_invalid;
    way_t                       hit_way, victim;
    logic                       unused_bits;

    assign req_tag     = address_i[ADDR_W-1 -: TAG_W];
    assign req_idx     = address_i[OFFSET_W+2 +: INDEX_W];
    assign req_off     = address_i[2 +: OFFSET_W];
    assign miss_tag    = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign miss_idx    = miss_addr_q[OFFSET_W+2 +: INDEX_W];
    assign word_lsb    = {req_off, {$clog2(LINE_W){1'b0}}};
    assign unused_bits = ^{address_i[1:0], miss_addr_q[OFFSET_W+1:0]};

    assign req        = c_read_i | c_wr_i;
    assign lookup_hit = req && hit && (state_q == IDLE);
    assign miss       = req && !hit && (state_q == IDLE);

    // The touched way becomes youngest; only ways younger than it age, so ages stay a permutation.
    function automatic ages_t lru_touch(input ages_t ages, input way_t way);
        ages_t result;
        result = ages;
        for (int w = 0; w < NWAYS; w++) begin
            if (way_t'(w) == way)
                result[w] = '0;
            else if (ages[w] < ages[way])
                result[w] = ages[w] + way_t'(1);
        end
        return result;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    // Descending scan leaves the lowest invalid way; otherwise evict the oldest.
    always_comb begin
        found_invalid = 1'b0;
        victim        = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                victim        = way_t'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (age_q[req_idx][w] == way_t'(NWAYS - 1))
                    victim = way_t'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        age_d       = age_q;
        victim_d    = victim_q;
        miss_addr_d = miss_addr_q;
        refill_d    = refill_q;
        case (state_q)
            IDLE: begin
                if (lookup_hit) begin
                    age_d[req_idx] = lru_touch(age_q[req_idx], hit_way);
                    if (c_wr_i) begin
                        data_d[req_idx][hit_way][word_lsb +: LINE_W] = c_write_data_i;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                end else if (miss) begin
                    victim_d    = victim;
                    miss_addr_d = address_i;
                    state_d     = (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
                                  ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                if (m_write_done && !c_m_busywait_i)
                    state_d = REFILL;
            end
            REFILL: begin
                if (m_read_done && !c_m_busywait_i) begin
                    refill_d = c_m_read_data_i;
                    state_d  = INSTALL;
                end
            end
            INSTALL: begin
                data_d[miss_idx][victim_q]  = refill_q;
                tag_d[miss_idx][victim_q]   = miss_tag;
                valid_d[miss_idx][victim_q] = 1'b1;
                dirty_d[miss_idx][victim_q] = 1'b0;
                age_d[miss_idx]             = lru_touch(age_q[miss_idx], victim_q);
                state_d                     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_m_wr_o         = 1'b0;
        c_m_read_o       = 1'b0;
        c_m_address_o    = '0;
        c_m_write_data_o = '0;
        case (state_q)
            WRITEBACK: begin
                c_m_wr_o         = !(m_write_done && !c_m_busywait_i);
                c_m_address_o    = {tag_q[miss_idx][victim_q], miss_idx};
                c_m_write_data_o = data_q[miss_idx][victim_q];
            end
            REFILL: begin
                c_m_read_o    = 1'b1;
                c_m_address_o = miss_addr_q[ADDR_W-1:OFFSET_W+2];
            end
            default: ;
        endcase
    end

    assign c_data_o     = lookup_hit ? data_q[req_idx][hit_way][word_lsb +: LINE_W] : '0;
    assign c_busywait_o = (state_q != IDLE) || miss;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            victim_q    <= '0;
            miss_addr_q <= '0;
            refill_q    <= '0;
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NWAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= way_t'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            age_q       <= age_d;
            victim_q    <= victim_d;
            miss_addr_q <= miss_addr_d;
            refill_q    <= refill_d;
        end
    end

endmodule

// File: tb/tb_wb_set_assoc_cache.sv
// Self-checking bench for wb_set_assoc_cache: table of core accesses scored against a queue of
// expected results, a behavioural block memory, and hand-written refill-stall and reset-abort sequences.
module tb_wb_set_assoc_cache;

    localparam int LAT = 2;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [31:0]  address_i;
    logic         c_read_i;
    logic         c_wr_i;
    logic [31:0]  c_write_data_i;
    logic [31:0]  c_data_o;
    logic         c_busywait_o;
    logic         c_m_read_o;
    logic         c_m_wr_o;
    logic [27:0]  c_m_address_o;
    logic [127:0] c_m_write_data_o;
    logic [127:0] c_m_read_data_i;
    logic         c_m_busywait_i;
    logic         m_read_done;
    logic         m_write_done;

    wb_set_assoc_cache dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .address_i        (address_i),
        .c_read_i         (c_read_i),
        .c_wr_i           (c_wr_i),
        .c_write_data_i   (c_write_data_i),
        .c_data_o         (c_data_o),
        .c_busywait_o     (c_busywait_o),
        .c_m_read_o       (c_m_read_o),
        .c_m_wr_o         (c_m_wr_o),
        .c_m_address_o    (c_m_address_o),
        .c_m_write_data_o (c_m_write_data_o),
        .c_m_read_data_i  (c_m_read_data_i),
        .c_m_busywait_i   (c_m_busywait_i),
        .m_read_done      (m_read_done),
        .m_write_done     (m_write_done)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        chkData;
        logic [31:0] expData;
        int          expStall;
        logic        chkWb;
        logic [27:0] expWbAddr;
        logic [31:0] expWbWord0;
    } vec_t;

    vec_t         vecs[$];
    vec_t         sbQueue[$];
    logic [127:0] mem [int];
    int           errors = 0;
    int           checks = 0;
    int           curVec = 0;

    function automatic logic [127:0] memBlock(input int blk);
        logic [23:0] b;
        b = blk[23:0];
        if (mem.exists(blk))
            return mem[blk];
        return {b, 8'd3, b, 8'd2, b, 8'd1, b, 8'd0};
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic rd, input logic wr,
                                input logic [31:0] wdata, input logic chkData,
                                input logic [31:0] expData, input int expStall,
                                input logic chkWb, input logic [27:0] expWbAddr,
                                input logic [31:0] expWbWord0);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wdata;
        v.chkData = chkData; v.expData = expData; v.expStall = expStall;
        v.chkWb = chkWb; v.expWbAddr = expWbAddr; v.expWbWord0 = expWbWord0;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL vec%0d %s: got 0x%0h expected 0x%0h", curVec, name, act, exp);
        end
    endtask

    // Pops the expected record for the access that just completed and scores what was observed.
    task automatic checkOutput(input int stall, input logic sawWb, input logic [27:0] wbAddr,
                               input logic [127:0] wbData, input logic [27:0] rfAddr);
        vec_t e;
        e = sbQueue.pop_front();
        checkValue("busy_released", c_busywait_o, 0);
        checkValue("stall_cycles", stall, e.expStall);
        checkValue("strobes_idle", {c_m_read_o, c_m_wr_o}, 0);
        if (e.chkData)
            checkValue("read_data", c_data_o, e.expData);
        if (e.expStall > 0)
            checkValue("refill_addr", rfAddr, e.addr[31:4]);
        if (e.chkWb) begin
            checkValue("wb_addr", wbAddr, e.expWbAddr);
            checkValue("wb_word0", wbData[31:0], e.expWbWord0);
        end else if (e.expStall > 0) begin
            checkValue("no_writeback", sawWb, 0);
        end
    endtask

    // Drives one core access at a negedge and plays the memory side until the core is released.
    task automatic applyStimulus(input vec_t v);
        int           stall, wcnt, rcnt;
        logic         sawWb, sawRf;
        logic [27:0]  wbAddr, rfAddr;
        logic [127:0] wbData;
        stall = 0; wcnt = 0; rcnt = 0;
        sawWb = 1'b0; sawRf = 1'b0;
        wbAddr = '1; rfAddr = '1; wbData = '1;
        address_i      = v.addr;
        c_read_i       = v.rd;
        c_wr_i         = v.wr;
        c_write_data_i = v.wdata;
        sbQueue.push_back(v);
        #1;
        while (c_busywait_o && stall < 50) begin
            if (c_m_wr_o) begin
                if (!sawWb) begin
                    sawWb = 1'b1; wbAddr = c_m_address_o; wbData = c_m_write_data_o;
                end
                wcnt++;
                if (wcnt == LAT) begin
                    mem[int'(c_m_address_o)] = c_m_write_data_o;
                    m_write_done = 1'b1;
                    wcnt = 0;
                end
            end else if (c_m_read_o) begin
                if (!sawRf) begin
                    sawRf = 1'b1; rfAddr = c_m_address_o;
                end
                rcnt++;
                if (rcnt == LAT) begin
                    c_m_read_data_i = memBlock(int'(c_m_address_o));
                    m_read_done = 1'b1;
                    rcnt = 0;
                end
            end
            @(negedge clk_i);
            m_write_done = 1'b0;
            m_read_done  = 1'b0;
            #1;
            stall++;
        end
        checkOutput(stall, sawWb, wbAddr, wbData, rfAddr);
        @(negedge clk_i);
        c_read_i = 1'b0;
        c_wr_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t e;
        int   n;

        mem[4] = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0001};

        vecs.push_back(mk(32'h040, 1, 0, 0,             1, 32'hA5A5_0001, 4, 0, 0,     0));
        vecs.push_back(mk(32'h048, 1, 0, 0,             1, 32'hA5A5_0002, 0, 0, 0,     0));
        vecs.push_back(mk(32'h040, 0, 1, 32'hDEAD_BEEF, 0, 0,             0, 0, 0,     0));
        vecs.push_back(mk(32'h040, 1, 0, 0,             1, 32'hDEAD_BEEF, 0, 0, 0,     0));
        vecs.push_back(mk(32'h140, 1, 0, 0,             1, 32'h0000_1400, 4, 0, 0,     0));
        vecs.push_back(mk(32'h240, 1, 0, 0,             1, 32'h0000_2400, 4, 0, 0,     0));
        vecs.push_back(mk(32'h340, 1, 0, 0,             1, 32'h0000_3400, 4, 0, 0,     0));
        vecs.push_back(mk(32'h140, 1, 0, 0,             1, 32'h0000_1400, 0, 0, 0,     0));
        vecs.push_back(mk(32'h240, 1, 0, 0,             1, 32'h0000_2400, 0, 0, 0,     0));
        vecs.push_back(mk(32'h340, 1, 0, 0,             1, 32'h0000_3400, 0, 0, 0,     0));
        vecs.push_back(mk(32'h440, 1, 0, 0,             1, 32'h0000_4400, 6, 1, 28'h4, 32'hDEAD_BEEF));
        vecs.push_back(mk(32'h040, 1, 0, 0,             1, 32'hDEAD_BEEF, 4, 0, 0,     0));
        vecs.push_back(mk(32'h040, 1, 1, 32'h1234_5678, 0, 0,             0, 0, 0,     0));
        vecs.push_back(mk(32'h040, 1, 0, 0,             1, 32'h1234_5678, 0, 0, 0,     0));
        vecs.push_back(mk(32'h540, 1, 0, 0,             1, 32'h0000_5400, 4, 0, 0,     0));
        vecs.push_back(mk(32'h640, 1, 0, 0,             1, 32'h0000_6400, 4, 0, 0,     0));
        vecs.push_back(mk(32'h740, 1, 0, 0,             1, 32'h0000_7400, 4, 0, 0,     0));
        vecs.push_back(mk(32'h840, 1, 0, 0,             1, 32'h0000_8400, 6, 1, 28'h4, 32'h1234_5678));
        vecs.push_back(mk(32'h740, 0, 1, 32'hCAFE_F00D, 0, 0,             0, 0, 0,     0));
        vecs.push_back(mk(32'h840, 1, 0, 0,             1, 32'h0000_8400, 0, 0, 0,     0));
        vecs.push_back(mk(32'h540, 1, 0, 0,             1, 32'h0000_5400, 0, 0, 0,     0));
        vecs.push_back(mk(32'h640, 1, 0, 0,             1, 32'h0000_6400, 0, 0, 0,     0));

        reset_n_i       = 1'b0;
        address_i       = '0;
        c_read_i        = 1'b0;
        c_wr_i          = 1'b0;
        c_write_data_i  = '0;
        c_m_read_data_i = '0;
        c_m_busywait_i  = 1'b0;
        m_read_done     = 1'b0;
        m_write_done    = 1'b0;
        #1;
        checkValue("reset_busy", c_busywait_o, 0);
        checkValue("reset_m_read", c_m_read_o, 0);
        checkValue("reset_m_wr", c_m_wr_o, 0);
        checkValue("reset_data", c_data_o, 0);
        checkValue("reset_m_addr", c_m_address_o, 0);
        checkValue("reset_m_wdata", c_m_write_data_o, 0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < vecs.size(); i++) begin
            curVec = i;
            applyStimulus(vecs[i]);
        end

        // Refill completion is ignored while memory still reports busy.
        curVec = 100;
        address_i = 32'h200;
        c_read_i  = 1'b1;
        sbQueue.push_back(mk(32'h200, 1, 0, 0, 1, 32'h0000_2000, 0, 0, 0, 0));
        n = 0;
        #1;
        while (!c_m_read_o && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        checkValue("t4_refill_strobe", c_m_read_o, 1);
        checkValue("t4_refill_addr", c_m_address_o, 28'h20);
        c_m_read_data_i = memBlock(32'h20);
        m_read_done     = 1'b1;
        c_m_busywait_i  = 1'b1;
        @(negedge clk_i);
        m_read_done    = 1'b0;
        c_m_busywait_i = 1'b0;
        #1;
        checkValue("t4_hold_refill", c_m_read_o, 1);
        m_read_done = 1'b1;
        @(negedge clk_i);
        m_read_done = 1'b0;
        #1;
        checkValue("t4_install_read_low", c_m_read_o, 0);
        checkValue("t4_install_busy", c_busywait_o, 1);
        @(negedge clk_i);
        #1;
        e = sbQueue.pop_front();
        checkValue("t4_busy_released", c_busywait_o, 0);
        checkValue("t4_read_data", c_data_o, e.expData);
        @(negedge clk_i);
        c_read_i = 1'b0;

        // Reset in the middle of a writeback drops the strobe at once and empties the cache.
        curVec = 101;
        address_i = 32'h940;
        c_read_i  = 1'b1;
        n = 0;
        #1;
        while (!c_m_wr_o && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        checkValue("t5_wb_strobe", c_m_wr_o, 1);
        checkValue("t5_wb_addr", c_m_address_o, 28'h74);
        checkValue("t5_wb_word0", c_m_write_data_o[31:0], 32'hCAFE_F00D);
        c_read_i  = 1'b0;
        reset_n_i = 1'b0;
        #1;
        checkValue("t5_wr_drop", c_m_wr_o, 0);
        checkValue("t5_addr_clear", c_m_address_o, 0);
        checkValue("t5_busy_clear", c_busywait_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        curVec = 102;
        applyStimulus(mk(32'h840, 1, 0, 0, 1, 32'h0000_8400, 4, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
